// File: rtl/dvs_ravens_pkg.sv
// Shared DVS camera constants, the packed event layout and the AER capture FSM states.
package dvs_ravens_pkg;

    // Sensor geometry; any address at or above these is outside the pixel array.
    localparam int DVS_WIDTH_PXLS        = 346;
    localparam int DVS_HEIGHT_PXLS       = 260;
    localparam int DVS_X_ADDR_BITS       = 9;
    localparam int DVS_Y_ADDR_BITS       = 9;

    // Microsecond timebase.
    localparam int TIMESTAMP_US_BITS     = 48;
    localparam int CLK_PERIOD_US_DIVISOR = 1000;

    // Packed event word {x, y, pol, ts}, MSB first.
    localparam int EVENT_BITS = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + 1 + TIMESTAMP_US_BITS;

    typedef struct packed {
        logic [DVS_X_ADDR_BITS-1:0]   x;
        logic [DVS_Y_ADDR_BITS-1:0]   y;
        logic                         pol;
        logic [TIMESTAMP_US_BITS-1:0] ts;
    } dvs_event_t;

    // Whether a valid row (y + timestamp) is currently latched.
    typedef enum logic {
        NO_ROW    = 1'b0,
        ROW_VALID = 1'b1
    } aer_state_t;

endpackage : dvs_ravens_pkg

// File: rtl/dvs_us_timebase.sv
// Free-running microsecond timestamp: a clock prescaler feeding a wide us counter.
module dvs_us_timebase
    import dvs_ravens_pkg::*;
#(
    parameter int US_DIV = CLK_PERIOD_US_DIVISOR
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ts_clear,
    output logic [TIMESTAMP_US_BITS-1:0] ts_us
);

    localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int TW = TIMESTAMP_US_BITS;

    logic [PW-1:0] presc;
    logic          tick;

    // One tick per microsecond, on the last prescaler count.
    assign tick = (presc == PW'(US_DIV - 1));

    // Prescaler and timestamp; a clear wins over a coincident tick.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            ts_us <= '0;
        end else if (ts_clear) begin
            presc <= '0;
            ts_us <= '0;
        end else if (tick) begin
            presc <= '0;
            ts_us <= ts_us + TW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule : dvs_us_timebase

// File: rtl/dvs_aer_event_ctrl.sv
// AER word capture: pairs row (y) and column (x, pol) words into timestamped events
// behind a one-deep, full-throughput output register.
module dvs_aer_event_ctrl
    import dvs_ravens_pkg::*;
#(
    parameter int X_BITS = DVS_X_ADDR_BITS,
    parameter int Y_BITS = DVS_Y_ADDR_BITS,
    parameter int US_DIV = CLK_PERIOD_US_DIVISOR,
    localparam int A_BITS  = (X_BITS > Y_BITS) ? X_BITS : Y_BITS,
    localparam int EV_BITS = X_BITS + Y_BITS + 1 + TIMESTAMP_US_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               ts_clear,
    input  logic               aer_valid,
    output logic               aer_ready,
    input  logic               aer_is_row,
    input  logic [A_BITS-1:0]  aer_addr,
    input  logic               aer_pol,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [EV_BITS-1:0] ev_data,
    output logic [15:0]        drop_cnt
);

    logic [TIMESTAMP_US_BITS-1:0] ts_us;
    logic [TIMESTAMP_US_BITS-1:0] ts_lat;
    logic [Y_BITS-1:0]            y_lat;
    aer_state_t                   state;
    aer_state_t                   state_nxt;
    logic [31:0]                  addr_ext;
    logic                         row_in_range;
    logic                         col_in_range;
    logic                         accept;
    logic                         row_load;
    logic                         ev_load;
    logic                         drop_inc;

    dvs_us_timebase #(
        .US_DIV (US_DIV)
    ) u_timebase (
        .clk      (clk),
        .rst_n    (rst_n),
        .ts_clear (ts_clear),
        .ts_us    (ts_us)
    );

    assign addr_ext     = 32'(aer_addr);
    assign row_in_range = (addr_ext < 32'(DVS_HEIGHT_PXLS));
    assign col_in_range = (addr_ext < 32'(DVS_WIDTH_PXLS));

    // Back-pressure, word decode and next-state; only column words can stall.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        aer_ready = !(en && !aer_is_row && ev_valid && !ev_ready);
        accept    = aer_valid && aer_ready;
        state_nxt = state;
        row_load  = 1'b0;
        ev_load   = 1'b0;
        drop_inc  = 1'b0;
        if (!en) begin
            state_nxt = NO_ROW;
        end else if (accept) begin
            if (aer_is_row) begin
                if (row_in_range) begin
                    row_load  = 1'b1;
                    state_nxt = ROW_VALID;
                end else begin
                    state_nxt = NO_ROW;
                end
            end else if ((state == ROW_VALID) && col_in_range) begin
                ev_load = 1'b1;
            end else begin
                drop_inc = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= NO_ROW;
        else        state <= state_nxt;
    end

    // Row latch: y and the timestamp current when the row word was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_lat  <= '0;
            ts_lat <= '0;
        end else if (row_load) begin
            y_lat  <= aer_addr[Y_BITS-1:0];
            ts_lat <= ts_us;
        end
    end

    // One-deep output register; a load may coincide with the draining handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid <= 1'b0;
            ev_data  <= '0;
        end else if (ev_load) begin
            ev_valid <= 1'b1;
            ev_data  <= {aer_addr[X_BITS-1:0], y_lat, aer_pol, ts_lat};
        end else if (ev_ready) begin
            ev_valid <= 1'b0;
        end
    end

    // Saturating count of discarded column words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             drop_cnt <= '0;
        else if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

endmodule : dvs_aer_event_ctrl
